flag_cdc_sched: RTL

- Source-domain scheduler that shares one flag CDC channel among N_REQ event requesters.
- Queues single-cycle event pulses in per-requester saturating counters and picks a requester round-robin.
- Drives the channel's level input (flag_o) with a high window of HOLD cycles, then a low window of GAP cycles. This guarantees the destination-side rising-edge detector sees every event.
- Presents the winner's ID on id_o, stable for the whole window, so the destination can sample it alongside the synchronized flag.

---
 rtl/flag_cdc_sched_pkg.sv | 18 +
 rtl/flag_cdc_sched_rr_arbiter.sv | 36 +++
 rtl/flag_cdc_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/flag_cdc_sched_pkg.sv
// Shared types and helpers for the flag CDC scheduler.
package flag_cdc_pkg;

    // Window FSM states: idle, flag high window, flag low window.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Width of the window down-counter: enough to hold max(HOLD, GAP).
    function automatic int win_cnt_w(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/flag_cdc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);

    localparam int unsigned N_U = N_REQ;

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // Scan requesters in rotating order and grant the first pending one.
    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_U; k++) begin
            w_idx = ID_W'((32'(i_last) + k) % N_U);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/flag_cdc_sched.sv
// Source-domain scheduler sharing one flag CDC channel among N_REQ requesters.
module flag_cdc_sched
    import flag_cdc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int HOLD  = 4,
    parameter int GAP   = 4,
    parameter int CNT_W = 3
) (
    input  logic             clkA,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             clr_ovf_i,
    output logic             flag_o,
    output logic [ID_W-1:0]  id_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] ovf_o
);

    localparam int              WIN_W   = win_cnt_w(HOLD, GAP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_HOLD = WIN_W'(HOLD - 1);
    localparam logic [WIN_W-1:0] WIN_GAP  = WIN_W'(GAP - 1);

    state_t           r_state, w_state_nxt;
    logic [WIN_W-1:0] r_win, w_win_nxt;
    logic [ID_W-1:0]  r_id, r_last;
    logic             r_flag;
    logic [CNT_W-1:0] r_cnt [N_REQ];
    logic [N_REQ-1:0] r_ovf, w_ovf_nxt;
    logic [N_REQ-1:0] w_pend, w_gnt, w_dec, w_ovf_set;
    logic [ID_W-1:0]  w_gnt_id;
    logic             w_any, w_grant_en;

    // Pending flags derived from the registered counters.
    always_comb begin
        w_pend = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_pend[i] = (r_cnt[i] != '0);
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req  (w_pend),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_id   (w_gnt_id),
        .o_any  (w_any)
    );

    // Next-state logic: grants happen only in IDLE or the last RELEASE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_grant_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ASSERT;
                    w_win_nxt   = WIN_HOLD;
                end
            end
            ASSERT: begin
                if (r_win == '0) begin
                    w_state_nxt = RELEASE;
                    w_win_nxt   = WIN_GAP;
                end else begin
                    w_win_nxt = r_win - WIN_W'(1);
                end
            end
            RELEASE: begin
                if (r_win == '0) begin
                    if (w_any) begin
                        w_grant_en  = 1'b1;
                        w_state_nxt = ASSERT;
                        w_win_nxt   = WIN_HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_win_nxt = r_win - WIN_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_win_nxt   = '0;
            end
        endcase
    end

    // Counter decrements and overflow detection; a simultaneous request and grant cancel out.
    always_comb begin
        w_dec     = w_grant_en ? w_gnt : '0;
        w_ovf_set = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_ovf_set[i] = req_i[i] && !w_dec[i] && (r_cnt[i] == CNT_MAX);
        end
        w_ovf_nxt = (clr_ovf_i ? '0 : r_ovf) | w_ovf_set;
    end

    // FSM, window counter and registered channel outputs; flag is a flop so the CDC input is glitch-free.
    always_ff @(posedge clkA) begin
        if (rst) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_flag  <= 1'b0;
            r_id    <= '0;
            r_last  <= ID_W'(N_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_flag  <= (w_state_nxt == ASSERT);
            if (w_grant_en) begin
                r_id   <= w_gnt_id;
                r_last <= w_gnt_id;
            end
        end
    end

    // Per-requester saturating pending counters and sticky overflow bits.
    always_ff @(posedge clkA) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_i[i] && !w_dec[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else if (!req_i[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    assign flag_o = r_flag;
    assign id_o   = r_id;
    assign busy_o = (r_state != IDLE);
    assign pend_o = w_pend;
    assign ovf_o  = r_ovf;

endmodule
